blink_multi: RTL and testbench

- Multi-channel LED/indicator driver, parametrised successor of the single-output blinker.
- One shared prescaler produces a periodic tick. Each channel has its own tick counter and a run-time configurable mode, period and on-time (duty).
- Sits between a register bank or control FSM and board LEDs/status pins. Also serves as the standard "alive" indicator in verification tops.

---
 rtl/blink_multi_if.sv | 26 ++
 rtl/blink_multi.sv | 142 ++++++++++++++
 tb/tb_blink_multi.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_multi_if.sv
// Configuration and status bundle for blink_multi.
// The master side (register bank / control FSM) drives per-channel load
// strobes and config fields; the slave side (the driver) returns the
// channel outputs, one-shot completion pulses and the shared tick.
interface blink_multi_if #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 16
);
    logic [CHANNELS-1:0]          load_i;
    logic [2*CHANNELS-1:0]        mode_i;
    logic [PERIOD_W*CHANNELS-1:0] period_i;
    logic [PERIOD_W*CHANNELS-1:0] duty_i;
    logic [CHANNELS-1:0]          blink_o;
    logic [CHANNELS-1:0]          done_o;
    logic                         tick_o;

    modport master (
        output load_i, mode_i, period_i, duty_i,
        input  blink_o, done_o, tick_o
    );

    modport slave (
        input  load_i, mode_i, period_i, duty_i,
        output blink_o, done_o, tick_o
    );
endinterface

// File: rtl/blink_multi.sv
// Multi-channel LED/indicator driver with a shared tick prescaler.
// Optional macro BLINK_MULTI_SYNC_EN adds sync_i, which clears the
// prescaler and all channel counters to phase-align every channel.
//
// Channel modes:
//   mode       | meaning
//   MODE_OFF   | output held low, ticks ignored
//   MODE_ON    | output held high, ticks ignored
//   MODE_BLINK | cnt wraps 0..period-1, output high while cnt < duty
//   MODE_SHOT  | one pass 0..period-1 while active, done pulse at the end
module blink_multi #(
    parameter int FREQUENCY = 25000000,
    parameter int TICK_HZ   = 1000,
    parameter int CHANNELS  = 4,
    parameter int PERIOD_W  = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
`ifdef BLINK_MULTI_SYNC_EN
    input  logic        sync_i,
`endif
    blink_multi_if.slave bus
);

    localparam int DIV   = FREQUENCY / TICK_HZ - 1;
    localparam int PRE_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [PRE_W-1:0] DIV_V = PRE_W'(DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_SHOT  = 2'b11
    } mode_e;

    logic sync;
`ifdef BLINK_MULTI_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick_q;

    mode_e               mode_q [CHANNELS];
    mode_e               mode_d [CHANNELS];
    logic [PERIOD_W-1:0] per_q  [CHANNELS];
    logic [PERIOD_W-1:0] per_d  [CHANNELS];
    logic [PERIOD_W-1:0] duty_q [CHANNELS];
    logic [PERIOD_W-1:0] duty_d [CHANNELS];
    logic [PERIOD_W-1:0] cnt_q  [CHANNELS];
    logic [PERIOD_W-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] act_q, act_d;
    logic [CHANNELS-1:0] blink_q, blink_d;
    logic [CHANNELS-1:0] done_q, done_d;

    // Prescaler next value; tick is registered so it is high exactly while pre_q == DIV.
    always_comb begin
        if (sync || (pre_q == DIV_V)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Per-channel next state: load beats sync beats tick; outputs decode the current state.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            mode_d[k] = mode_q[k];
            per_d[k]  = per_q[k];
            duty_d[k] = duty_q[k];
            cnt_d[k]  = cnt_q[k];
            act_d[k]  = act_q[k];
            done_d[k] = 1'b0;

            case (mode_q[k])
                MODE_ON:    blink_d[k] = 1'b1;
                MODE_BLINK: blink_d[k] = (cnt_q[k] < duty_q[k]);
                MODE_SHOT:  blink_d[k] = act_q[k] && (cnt_q[k] < duty_q[k]);
                default:    blink_d[k] = 1'b0;
            endcase

            if (bus.load_i[k]) begin
                mode_d[k] = mode_e'(bus.mode_i[2*k +: 2]);
                // A zero period would never wrap; treat it as a single-tick period.
                per_d[k]  = (bus.period_i[PERIOD_W*k +: PERIOD_W] == '0) ?
                            PERIOD_W'(1) : bus.period_i[PERIOD_W*k +: PERIOD_W];
                duty_d[k] = bus.duty_i[PERIOD_W*k +: PERIOD_W];
                cnt_d[k]  = '0;
                act_d[k]  = (bus.mode_i[2*k +: 2] == 2'(MODE_SHOT));
            end else if (sync) begin
                cnt_d[k]  = '0;
            end else if (tick_q && ((mode_q[k] == MODE_BLINK) ||
                                    ((mode_q[k] == MODE_SHOT) && act_q[k]))) begin
                if (cnt_q[k] == per_q[k] - PERIOD_W'(1)) begin
                    cnt_d[k] = '0;
                    if (mode_q[k] == MODE_SHOT) begin
                        act_d[k]  = 1'b0;
                        done_d[k] = 1'b1;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + PERIOD_W'(1);
                end
            end
        end
    end

    // State and registered outputs, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            act_q   <= '0;
            blink_q <= '0;
            done_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                mode_q[k] <= MODE_OFF;
                per_q[k]  <= PERIOD_W'(1);
                duty_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            tick_q  <= (pre_d == DIV_V);
            act_q   <= act_d;
            blink_q <= blink_d;
            done_q  <= done_d;
            for (int k = 0; k < CHANNELS; k++) begin
                mode_q[k] <= mode_d[k];
                per_q[k]  <= per_d[k];
                duty_q[k] <= duty_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign bus.blink_o = blink_q;
    assign bus.done_o  = done_q;
    assign bus.tick_o  = tick_q;

endmodule

// File: tb/tb_blink_multi.sv
// Bench for blink_multi: cycle scoreboard against a spec-level model,
// a table of per-channel configurations with hand-derived high/done
// counts, and hand-written sequences for latency, reload and reset.
module tb_blink_multi;

    localparam int CH  = 4;
    localparam int PW  = 8;
    localparam int DIV = 9;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    logic sync_i = 1'b0;

    always #5 clk_i = ~clk_i;

    blink_multi_if #(.CHANNELS(CH), .PERIOD_W(PW)) bus ();

    blink_multi #(
        .FREQUENCY(1000),
        .TICK_HZ  (100),
        .CHANNELS (CH),
        .PERIOD_W (PW)
    ) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
`ifdef BLINK_MULTI_SYNC_EN
        .sync_i(sync_i),
`endif
        .bus   (bus)
    );

    typedef struct packed {
        logic [CH-1:0] blink;
        logic [CH-1:0] done;
        logic          tick;
    } exp_t;

    typedef struct {
        string      name;
        int         ch;
        logic [1:0] md;
        logic [7:0] per;
        logic [7:0] du;
        int         win;
        int         exp_hi;
        int         exp_dn;
    } vec_t;

    exp_t          sb_q[$];
    logic [1:0]    m_mode [CH];
    logic [PW-1:0] m_per  [CH];
    logic [PW-1:0] m_duty [CH];
    logic [PW-1:0] m_cnt  [CH];
    logic          m_act  [CH];
    int            m_pre;

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_mode[k] = 2'b00;
            m_per[k]  = 8'd1;
            m_duty[k] = 8'd0;
            m_cnt[k]  = 8'd0;
            m_act[k]  = 1'b0;
        end
        m_pre = 0;
        sb_q.delete();
    endtask

    function automatic logic decode(int k);
        case (m_mode[k])
            2'b01:   return 1'b1;
            2'b10:   return m_cnt[k] < m_duty[k];
            2'b11:   return m_act[k] && (m_cnt[k] < m_duty[k]);
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_step();
        exp_t       e;
        logic [7:0] p;
        bit         tk;
        e  = '0;
        tk = (m_pre == DIV);
        for (int k = 0; k < CH; k++) begin
            e.blink[k] = decode(k);
            if (bus.load_i[k]) begin
                p         = bus.period_i[PW*k +: PW];
                m_mode[k] = bus.mode_i[2*k +: 2];
                m_per[k]  = (p == 8'd0) ? 8'd1 : p;
                m_duty[k] = bus.duty_i[PW*k +: PW];
                m_cnt[k]  = 8'd0;
                m_act[k]  = (bus.mode_i[2*k +: 2] == 2'b11);
            end else if (sync_i) begin
                m_cnt[k] = 8'd0;
            end else if (tk && (m_mode[k] == 2'b10 || (m_mode[k] == 2'b11 && m_act[k]))) begin
                if (m_cnt[k] == m_per[k] - 8'd1) begin
                    m_cnt[k] = 8'd0;
                    if (m_mode[k] == 2'b11) begin
                        m_act[k]  = 1'b0;
                        e.done[k] = 1'b1;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] + 8'd1;
                end
            end
        end
        m_pre  = (sync_i || m_pre == DIV) ? 0 : m_pre + 1;
        e.tick = (m_pre == DIV);
        sb_q.push_back(e);
    endtask

    // One clock: model pushes at the edge, DUT outputs compared at the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty actual=none expected=entry t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("sb_out", 32'({bus.blink_o, bus.done_o, bus.tick_o}), 32'(e));
        end
    endtask

    task automatic align_tick();
        int n = 0;
        while (bus.tick_o !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("align_tick", 32'(bus.tick_o), 32'd1);
    endtask

    task automatic do_load(int ch, logic [1:0] md, logic [7:0] per, logic [7:0] du);
        bus.mode_i[2*ch +: 2]     = md;
        bus.period_i[PW*ch +: PW] = per;
        bus.duty_i[PW*ch +: PW]   = du;
        bus.load_i[ch]            = 1'b1;
        step();
        bus.load_i[ch]            = 1'b0;
    endtask

    task automatic run_count(int ch, int w, output int hi, output int dn);
        hi = 0;
        dn = 0;
        for (int i = 0; i < w; i++) begin
            step();
            if (bus.blink_o[ch]) hi++;
            if (bus.done_o[ch])  dn++;
        end
    endtask

    vec_t vt[11];

    initial begin
        int hi, dn, tk;

        vt[0]  = '{"blink50",     0, 2'b10, 8'd4, 8'd2, 80, 40, 0};
        vt[1]  = '{"per0_duty0",  1, 2'b10, 8'd0, 8'd0, 80,  0, 0};
        vt[2]  = '{"duty_gt_per", 2, 2'b10, 8'd3, 8'd5, 80, 80, 0};
        vt[3]  = '{"shot_p5d2",   3, 2'b11, 8'd5, 8'd2, 80, 20, 1};
        vt[4]  = '{"mode_on",     0, 2'b01, 8'd0, 8'd0, 80, 80, 0};
        vt[5]  = '{"mode_off",    0, 2'b00, 8'd4, 8'd2, 80,  0, 0};
        vt[6]  = '{"blink_p5d1",  1, 2'b10, 8'd5, 8'd1, 80, 20, 0};
        vt[7]  = '{"duty0",       2, 2'b10, 8'd4, 8'd0, 80,  0, 0};
        vt[8]  = '{"shot_p2d2",   3, 2'b11, 8'd2, 8'd2, 80, 20, 1};
        vt[9]  = '{"duty_eq_per", 1, 2'b10, 8'd3, 8'd3, 60, 60, 0};
        vt[10] = '{"shot_reload", 3, 2'b11, 8'd5, 8'd2, 80, 20, 1};

        bus.load_i   = '0;
        bus.mode_i   = '0;
        bus.period_i = '0;
        bus.duty_i   = '0;
        model_reset();

        repeat (3) @(negedge clk_i);
        check("rst_outputs", 32'({bus.blink_o, bus.done_o, bus.tick_o}), 32'd0);
        rstn_i = 1'b1;

        // Idle after reset: outputs stay low, tick every 10th clock.
        tk = 0; hi = 0; dn = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.tick_o)        tk++;
            if (bus.blink_o != 0)  hi++;
            if (bus.done_o != 0)   dn++;
        end
        check("idle_ticks", tk, 20);
        check("idle_blink", hi, 0);
        check("idle_done",  dn, 0);

        // Table of configurations, each loaded on a tick cycle.
        for (int v = 0; v < 11; v++) begin
            align_tick();
            do_load(vt[v].ch, vt[v].md, vt[v].per, vt[v].du);
            run_count(vt[v].ch, vt[v].win, hi, dn);
            check({vt[v].name, "_high"}, hi, vt[v].exp_hi);
            check({vt[v].name, "_done"}, dn, vt[v].exp_dn);
        end

        // Load on a tick: one cycle latency, first on-phase lasts duty*10 clocks.
        align_tick();
        do_load(0, 2'b10, 8'd4, 8'd2);
        check("load_latency_old", 32'(bus.blink_o[0]), 32'd0);
        step();
        check("load_latency_new", 32'(bus.blink_o[0]), 32'd1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.blink_o[0]) hi++;
            else break;
        end
        check("first_on_phase", hi, 20);

        // Reload a one-shot at its second tick: only the new shot completes.
        align_tick();
        do_load(3, 2'b11, 8'd5, 8'd2);
        repeat (19) step();
        check("tick2_phase", 32'(bus.tick_o), 32'd1);
        do_load(3, 2'b11, 8'd5, 8'd2);
        run_count(3, 45, hi, dn);
        check("aborted_shot_done", dn, 0);
        run_count(3, 15, hi, dn);
        check("new_shot_done", dn, 1);

`ifdef BLINK_MULTI_SYNC_EN
        // Two channels loaded one tick apart are realigned by sync_i.
        align_tick();
        do_load(1, 2'b10, 8'd4, 8'd2);
        align_tick();
        do_load(2, 2'b10, 8'd4, 8'd2);
        repeat (5) step();
        align_tick();
        do_load(0, 2'b10, 8'd4, 8'd2);
        repeat (3) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        step();
        dn = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if ((bus.blink_o[0] != bus.blink_o[1]) || (bus.blink_o[1] != bus.blink_o[2])) dn++;
        end
        check("sync_aligned", dn, 0);
`endif

        // Asynchronous reset while ch0 is in its on-phase.
        hi = 0;
        while (!bus.blink_o[0] && hi < 50) begin
            step();
            hi++;
        end
        check("pre_reset_high", 32'(bus.blink_o[0]), 32'd1);
        #2 rstn_i = 1'b0;
        #1 check("async_reset_out", 32'({bus.blink_o, bus.done_o, bus.tick_o}), 32'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        run_count(0, 40, hi, dn);
        check("post_reset_high", hi, 0);
        check("post_reset_done", dn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
